shift_sequencer: RTL

//  Multi-position shift controller wrapped around the single-position

---
 rtl/shift_sequencer_if.sv | 28 ++
 rtl/shift_sequencer.sv | 86 ++++++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
// Operand/result handshake plus the shifter return path for shift_sequencer.
// The master side is the surrounding datapath: it supplies the request and the
// single-position shifter that turns sh_b/sh_hselect into sh_h.
interface shift_sequencer_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
);
   logic             start;
   logic             dir;
   logic [CNT_W-1:0] amount;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] sh_b;
   logic [1:0]       sh_hselect;
   logic [WIDTH-1:0] sh_h;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, dir, amount, operand, sh_h,
      input  sh_b, sh_hselect, busy, done, result
   );

   modport slave (
      input  start, dir, amount, operand, sh_h,
      output sh_b, sh_hselect, busy, done, result
   );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-position logical shifter built by iterating a single-position shifter:
// the work register feeds sh_b and takes sh_h back once per SHIFT cycle.
module shift_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
) (
   input logic              i_clk,
   input logic              i_rst_n,
   shift_sequencer_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           r_state, w_state_next;
   logic [WIDTH-1:0] r_work, w_work_next;
   logic [CNT_W-1:0] r_count, w_count_next;
   logic             r_dir, w_dir_next;
   logic [WIDTH-1:0] r_result;
   logic             w_done_entry;

   // Next-state and datapath update; start is only looked at in IDLE.
   always_comb begin
      w_state_next = r_state;
      w_work_next  = r_work;
      w_count_next = r_count;
      w_dir_next   = r_dir;
      unique case (r_state)
         StIdle: begin
            if (bus.start) begin
               w_work_next  = bus.operand;
               w_count_next = bus.amount;
               w_dir_next   = bus.dir;
               w_state_next = (bus.amount == '0) ? StDone : StShift;
            end
         end
         StShift: begin
            w_work_next  = bus.sh_h;
            w_count_next = r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) begin
               w_state_next = StDone;
            end
         end
         StDone: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // Result is captured only on the transition into DONE so it holds across later ops.
   assign w_done_entry = (w_state_next == StDone) && (r_state != StDone);

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_work   <= '0;
         r_count  <= '0;
         r_dir    <= 1'b0;
         r_result <= '0;
      end else begin
         r_state <= w_state_next;
         r_work  <= w_work_next;
         r_count <= w_count_next;
         r_dir   <= w_dir_next;
         if (w_done_entry) begin
            r_result <= w_work_next;
         end
      end
   end

   // Outputs decoded from registered state only; 2'b11 is never produced.
   always_comb begin
      bus.sh_b       = r_work;
      bus.sh_hselect = 2'b00;
      if (r_state == StShift) begin
         bus.sh_hselect = r_dir ? 2'b10 : 2'b01;
      end
      bus.busy   = (r_state != StIdle);
      bus.done   = (r_state == StDone);
      bus.result = r_result;
   end

endmodule
